// File: rtl/io_responder_pkg.sv
// Register offsets, control-field layout and IRQ bit positions shared by the
// memory-mapped I/O responder and its timer.
package io_responder_pkg;

    localparam int NUM_REGS = 6;

    localparam logic [2:0] OFF_OUT   = 3'd0;
    localparam logic [2:0] OFF_IN    = 3'd1;
    localparam logic [2:0] OFF_TLOAD = 3'd2;
    localparam logic [2:0] OFF_TCNT  = 3'd3;
    localparam logic [2:0] OFF_TCTRL = 3'd4;
    localparam logic [2:0] OFF_IRQ   = 3'd5;

    localparam int TCTRL_EN        = 0;
    localparam int TCTRL_AUTO      = 1;
    localparam int TCTRL_PRESC_LSB = 8;

    localparam int IRQ_TIMER   = 0;
    localparam int IRQ_IN0     = 1;
    localparam int IRQ_EXT_LSB = 2;

    typedef struct packed {
        logic [7:0] presc;
        logic       auto_rl;
        logic       en;
    } tctrl_t;

    // Bits [7:2] of TCTRL are not stored and always read back as zero.
    function automatic logic [15:0] tctrl_to_word(input tctrl_t t);
        tctrl_to_word = {t.presc, 6'b000000, t.auto_rl, t.en};
    endfunction

endpackage

// File: rtl/io_responder_timer.sv
// Down-counting timer with prescaler, optional auto-reload and a one-cycle
// expiry strobe; a load always overrides a tick in the same cycle.
module io_responder_timer
    import io_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        auto,
    input  logic [7:0]  presc,
    output logic        en_clr,
    output logic        expire,
    output logic [15:0] tcnt
);

    logic [7:0] presc_cnt;
    logic       presc_done;
    logic       tick;

    // >= keeps the prescaler from running to 255 if PRESC is lowered mid-count.
    assign presc_done = (presc_cnt >= presc);
    assign tick       = en && !load && presc_done;
    assign expire     = tick && (tcnt == 16'd0);
    assign en_clr     = expire && !auto;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
            tcnt      <= '0;
        end else if (load) begin
            presc_cnt <= '0;
            tcnt      <= load_val;
        end else if (en) begin
            if (presc_done) begin
                presc_cnt <= '0;
                if (tcnt != 16'd0) begin
                    tcnt <= tcnt - 16'd1;
                end else if (auto) begin
                    tcnt <= load_val;
                end
            end else begin
                presc_cnt <= presc_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O slave: six-word register window with output port,
// synchronised input port, timer and level interrupt controller.
module io_responder
    import io_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addresses,
    inout  wire  [15:0] data,
    input  logic        cpu_oe,
    input  logic [15:0] in_port,
    input  logic [5:0]  ext_irq,
    output logic [15:0] out_port,
    output logic [7:0]  int_e
);

    logic [15:0] rel_addr;
    logic        sel;
    logic [2:0]  off;
    logic        wr_en;
    logic        wr_out;
    logic        wr_tload;
    logic        wr_tctrl;
    logic        wr_irq;

    logic [SYNC_STAGES-1:0][15:0] in_pipe;
    logic [SYNC_STAGES-1:0][5:0]  ext_pipe;
    logic [15:0] in_sync;
    logic [5:0]  ext_sync;
    logic [6:0]  src_now;
    logic [6:0]  edge_hist;
    logic [6:0]  src_rise;

    logic [15:0] out_q;
    logic [15:0] tload_q;
    logic [15:0] tload_nxt;
    tctrl_t      tctrl_q;
    logic [7:0]  pending_q;
    logic [7:0]  mask_q;
    logic [7:0]  set_vec;
    logic [7:0]  clr_vec;

    logic        timer_run;
    logic        timer_en_clr;
    logic        timer_expire;
    logic [15:0] tcnt;
    logic [15:0] rd_val;

    assign rel_addr = addresses - BASE_ADDR;
    assign sel      = (rel_addr < 16'(NUM_REGS));
    assign off      = rel_addr[2:0];
    assign wr_en    = sel && cpu_oe;
    assign wr_out   = wr_en && (off == OFF_OUT);
    assign wr_tload = wr_en && (off == OFF_TLOAD);
    assign wr_tctrl = wr_en && (off == OFF_TCTRL);
    assign wr_irq   = wr_en && (off == OFF_IRQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_pipe  <= '0;
            ext_pipe <= '0;
        end else begin
            in_pipe  <= {in_pipe[SYNC_STAGES-2:0], in_port};
            ext_pipe <= {ext_pipe[SYNC_STAGES-2:0], ext_irq};
        end
    end

    assign in_sync  = in_pipe[SYNC_STAGES-1];
    assign ext_sync = ext_pipe[SYNC_STAGES-1];

    assign src_now  = {ext_sync, in_sync[0]};
    assign src_rise = src_now & ~edge_hist;

    assign set_vec[IRQ_TIMER]             = timer_expire;
    assign set_vec[IRQ_IN0]               = src_rise[0];
    assign set_vec[IRQ_EXT_LSB +: 6]      = src_rise[6:1];
    assign clr_vec = wr_irq ? data[7:0] : 8'h00;

    // A write that sets TLOAD feeds the timer directly so load and reload see the new value.
    assign tload_nxt = wr_tload ? data : tload_q;
    // Only a write clearing EN suppresses the tick in its own cycle; setting EN takes effect next cycle.
    assign timer_run = tctrl_q.en && !(wr_tctrl && !data[TCTRL_EN]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            tload_q   <= '0;
            tctrl_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            edge_hist <= '0;
        end else begin
            edge_hist <= src_now;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            if (wr_out) begin
                out_q <= data;
            end
            if (wr_tload) begin
                tload_q <= data;
            end
            if (wr_tctrl) begin
                tctrl_q.presc   <= data[TCTRL_PRESC_LSB +: 8];
                tctrl_q.auto_rl <= data[TCTRL_AUTO];
                tctrl_q.en      <= data[TCTRL_EN];
            end else if (timer_en_clr) begin
                tctrl_q.en <= 1'b0;
            end
            if (wr_irq) begin
                mask_q <= data[15:8];
            end
        end
    end

    io_responder_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (wr_tload),
        .load_val (tload_nxt),
        .en       (timer_run),
        .auto     (tctrl_q.auto_rl),
        .presc    (tctrl_q.presc),
        .en_clr   (timer_en_clr),
        .expire   (timer_expire),
        .tcnt     (tcnt)
    );

    always_comb begin
        rd_val = 16'h0000;
        case (off)
            OFF_OUT:   rd_val = out_q;
            OFF_IN:    rd_val = in_sync;
            OFF_TLOAD: rd_val = tload_q;
            OFF_TCNT:  rd_val = tcnt;
            OFF_TCTRL: rd_val = tctrl_to_word(tctrl_q);
            OFF_IRQ:   rd_val = {mask_q, pending_q};
            default:   rd_val = 16'h0000;
        endcase
    end

    assign data     = (sel && !cpu_oe && reset) ? rd_val : 16'bz;
    assign out_port = out_q;
    assign int_e    = pending_q & mask_q;

endmodule
